alu_operand_stage: RTL

- Issue/operand-fetch stage directly upstream of the 16-bit ALU.
- Holds the register file and accepts decoded instructions over a valid/ready handshake.
- Reads and forwards operands, and presents a registered {operation, input_a, input_b, rd} bundle to the ALU.
- Takes ALU results back on a write-back port, and uses a per-register pending scoreboard to stall read-after-write and write-after-write hazards.

---
 rtl/alu_operand_stage.sv | 104 ++++++++++
 1 files changed

// File: rtl/alu_operand_stage.sv
// Operand-fetch stage in front of the 16-bit ALU: register file, write-back bypass,
// per-register pending scoreboard for RAW/WAW stalls, and a registered operand bundle.
module alu_operand_stage #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned REGS  = 8,
  parameter int unsigned AW    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [AW-1:0]    in_rd,
  input  logic [AW-1:0]    in_rs1,
  input  logic [AW-1:0]    in_rs2,
  input  logic [WIDTH-1:0] in_imm,
  input  logic             in_use_imm,
  input  logic             wb_en,
  input  logic [AW-1:0]    wb_addr,
  input  logic [WIDTH-1:0] wb_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_op,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [AW-1:0]    out_rd,
  output logic             busy
);

  logic [WIDTH-1:0] rf [REGS];
  logic [REGS-1:0]  pending;
  logic [REGS-1:0]  wb_hit;
  logic [REGS-1:0]  pend_eff;
  logic             hazard;
  logic             accept;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;

  // Hazard detection and operand selection; a same-cycle write-back both
  // releases the hazard and supplies the operand through the bypass.
  always_comb begin
    wb_hit = '0;
    if (wb_en) wb_hit[wb_addr] = 1'b1;
    pend_eff = pending & ~wb_hit;

    hazard = 1'b0;
    if (in_rs1 != '0 && pend_eff[in_rs1]) hazard = 1'b1;
    if (!in_use_imm && in_rs2 != '0 && pend_eff[in_rs2]) hazard = 1'b1;
    if (in_rd != '0 && pend_eff[in_rd]) hazard = 1'b1;

    opa = '0;
    if (in_rs1 != '0) begin
      if (wb_en && wb_addr == in_rs1) opa = wb_data;
      else                            opa = rf[in_rs1];
    end

    opb = '0;
    if (in_use_imm) begin
      opb = in_imm;
    end else if (in_rs2 != '0) begin
      if (wb_en && wb_addr == in_rs2) opb = wb_data;
      else                            opb = rf[in_rs2];
    end
  end

  assign in_ready = (~out_valid | out_ready) & ~hazard;
  assign accept   = in_valid & in_ready;
  assign busy     = |pending;

  // Register file and scoreboard; the accept-side set is ordered last so it
  // wins over a same-cycle write-back to the same register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(REGS); i++) rf[i] <= '0;
      pending <= '0;
    end else begin
      if (wb_en && wb_addr != '0) begin
        rf[wb_addr]      <= wb_data;
        pending[wb_addr] <= 1'b0;
      end
      if (accept && in_rd != '0) pending[in_rd] <= 1'b1;
    end
  end

  // Output bundle register: load on accept, drain on out_ready, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_op    <= '0;
      out_a     <= '0;
      out_b     <= '0;
      out_rd    <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_op    <= in_op;
      out_a     <= opa;
      out_b     <= opb;
      out_rd    <= in_rd;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
